// File: rtl/adc_pkt_pkg.sv
// Shared types and helpers for the ADC sample packetizer.
// Imported by the RTL and by its bench.
package adc_pkt_pkg;

    localparam int BYTE_W   = 8;
    localparam int SAMPLE_W = 16;

    localparam logic [BYTE_W-1:0] HEADER_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        WAIT_SMP,
        MSB,
        LSB,
        CSUM
    } state_t;

    // Byte that brings the 8-bit packet sum to zero.
    function automatic logic [BYTE_W-1:0] csum_of(input logic [BYTE_W-1:0] sum);
        return 8'h00 - sum;
    endfunction

endpackage

// File: rtl/adc_sample_packetizer.sv
// Pops 16-bit samples from an FWFT FIFO and frames them into
// header/seq/samples/checksum byte packets on a valid/ready stream.
module adc_sample_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int                SAMPLES_PER_PKT = 4,
    parameter logic [BYTE_W-1:0] HEADER_BYTE     = HEADER_BYTE_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [SAMPLE_W-1:0] i_fifo_data,
    input  logic                i_fifo_empty,
    output logic                o_fifo_rd,
    output logic [BYTE_W-1:0]   o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_busy,
    output logic [BYTE_W-1:0]   o_seq
);

    localparam int CW = $clog2(SAMPLES_PER_PKT + 1);

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [BYTE_W-1:0]   seq_q, seq_d;
    logic [BYTE_W-1:0]   acc_q, acc_d;
    logic [SAMPLE_W-1:0] smp_q, smp_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                xfer;
    logic                fetch;
    logic                rd;
    logic [CW-1:0]       cnt_inc;
    logic [BYTE_W-1:0]   acc_nxt;

    assign xfer    = valid_q && i_tx_ready;
    assign cnt_inc = cnt_q + CW'(1);
    assign acc_nxt = acc_q + data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        seq_d   = seq_q;
        acc_d   = acc_q;
        smp_d   = smp_q;
        cnt_d   = cnt_q;
        fetch   = 1'b0;
        rd      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_enable && !i_fifo_empty) begin
                    state_d = HDR;
                    data_d  = HEADER_BYTE;
                    valid_d = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    acc_d   = acc_nxt;
                    state_d = SEQ;
                    data_d  = seq_q;
                end
            end
            SEQ: begin
                if (xfer) begin
                    acc_d = acc_nxt;
                    fetch = 1'b1;
                end
            end
            WAIT_SMP: fetch = 1'b1;
            MSB: begin
                if (xfer) begin
                    acc_d   = acc_nxt;
                    state_d = LSB;
                    data_d  = smp_q[7:0];
                end
            end
            LSB: begin
                if (xfer) begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(SAMPLES_PER_PKT)) begin
                        state_d = CSUM;
                        data_d  = csum_of(acc_nxt);
                    end else begin
                        fetch = 1'b1;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    seq_d   = seq_q + 8'd1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Fetching on the same edge as the previous transfer keeps
        // the stream gap-free whenever the FIFO already holds a word.
        if (fetch) begin
            if (!i_fifo_empty) begin
                rd      = 1'b1;
                smp_d   = i_fifo_data;
                data_d  = i_fifo_data[15:8];
                valid_d = 1'b1;
                state_d = MSB;
            end else begin
                valid_d = 1'b0;
                state_d = WAIT_SMP;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            seq_q   <= '0;
            acc_q   <= '0;
            smp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            seq_q   <= seq_d;
            acc_q   <= acc_d;
            smp_q   <= smp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_fifo_rd  = rd;
    assign o_tx_data  = data_q;
    assign o_tx_valid = valid_q;
    assign o_busy     = (state_q != IDLE);
    assign o_seq      = seq_q;

endmodule

// File: tb/tb_adc_sample_packetizer.sv
// Directed bench: instance A has N=1, instance B has N=4; each has
// its own FWFT FIFO model and byte capture queue.
module tb_adc_sample_packetizer;
    import adc_pkt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic rdy = 1'b1;

    logic [15:0] fd_a = '0, fd_b = '0;
    logic        fe_a = 1'b1, fe_b = 1'b1;
    logic        rd_a, rd_b;
    logic [7:0]  dat_a, dat_b;
    logic        vld_a, vld_b;
    logic        busy_a, busy_b;
    logic [7:0]  seq_a, seq_b;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int pops_a = 0, pops_b = 0;

    logic [15:0] qa[$], qb[$];
    logic [7:0]  cap_a[$], cap_b[$];
    int          cyc_a[$];

    logic        held = 1'b0;
    logic [7:0]  held_d = '0;

    always #5 clk = ~clk;

    adc_sample_packetizer #(.SAMPLES_PER_PKT(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
        .i_fifo_data(fd_a), .i_fifo_empty(fe_a), .o_fifo_rd(rd_a),
        .o_tx_data(dat_a), .o_tx_valid(vld_a), .i_tx_ready(rdy),
        .o_busy(busy_a), .o_seq(seq_a)
    );

    adc_sample_packetizer #(.SAMPLES_PER_PKT(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
        .i_fifo_data(fd_b), .i_fifo_empty(fe_b), .o_fifo_rd(rd_b),
        .o_tx_data(dat_b), .o_tx_valid(vld_b), .i_tx_ready(rdy),
        .o_busy(busy_b), .o_seq(seq_b)
    );

    always @(posedge clk) begin
        cycle++;
        if (rd_a) begin
            checks++;
            if (fe_a !== 1'b0) begin
                errors++;
                $display("FAIL pop_empty_a: popped with empty=%b", fe_a);
            end
            if (qa.size() > 0) void'(qa.pop_front());
            pops_a++;
        end
        if (rd_b) begin
            checks++;
            if (fe_b !== 1'b0) begin
                errors++;
                $display("FAIL pop_empty_b: popped with empty=%b", fe_b);
            end
            if (qb.size() > 0) void'(qb.pop_front());
            pops_b++;
        end
        if (vld_a && rdy) begin
            cap_a.push_back(dat_a);
            cyc_a.push_back(cycle);
        end
        if (vld_b && rdy) cap_b.push_back(dat_b);
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (vld_b !== 1'b1 || dat_b !== held_d) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h",
                             vld_b, dat_b, held_d);
                end
            end
            held   = vld_b && !rdy;
            held_d = dat_b;
        end
    end

    always @(negedge clk) begin
        fe_a = (qa.size() == 0);
        fd_a = fe_a ? 16'h0 : qa[0];
        fe_b = (qb.size() == 0);
        fd_b = fe_b ? 16'h0 : qb[0];
    end

    function automatic void mk_pkt(input logic [7:0] sq,
                                   input logic [15:0] s[$],
                                   output logic [7:0] e[$]);
        logic [7:0] sum;
        e = {};
        e.push_back(8'hA5);
        e.push_back(sq);
        foreach (s[k]) begin
            e.push_back(s[k][15:8]);
            e.push_back(s[k][7:0]);
        end
        sum = 8'h00;
        foreach (e[k]) sum = sum + e[k];
        e.push_back(csum_of(sum));
    endfunction

    task automatic wait_bytes(input bit use_b, input int n,
                              input bit rnd, input int budget);
        int c;
        c = 0;
        while ((use_b ? cap_b.size() : cap_a.size()) < n && c < budget) begin
            @(negedge clk);
            if (rnd) rdy = 1'($urandom_range(0, 1));
            c++;
        end
        if ((use_b ? cap_b.size() : cap_a.size()) < n) begin
            errors++;
            $display("FAIL timeout: got %0d bytes want %0d",
                     use_b ? cap_b.size() : cap_a.size(), n);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({vld_a, dat_a, busy_a, seq_a, rd_a} !== 19'h0) begin
            errors++;
            $display("FAIL reset_a: v=%b d=%h b=%b s=%h r=%b want 0",
                     vld_a, dat_a, busy_a, seq_a, rd_a);
        end
        checks++;
        if ({vld_b, dat_b, busy_b, seq_b, rd_b} !== 19'h0) begin
            errors++;
            $display("FAIL reset_b: v=%b d=%h b=%b s=%h r=%b want 0",
                     vld_b, dat_b, busy_b, seq_b, rd_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] exp_b[5];
        exp_b = '{8'hA5, 8'h00, 8'hB2, 8'h6E, 8'h3B};
        cap_a = {};
        cyc_a = {};
        pops_a = 0;
        qa.push_back(16'hB26E);
        en = 1'b1;
        rdy = 1'b1;
        wait_bytes(1'b0, 5, 1'b0, 50);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= cap_a.size() || cap_a[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL single_byte%0d: got %h want %h", k,
                         k < cap_a.size() ? cap_a[k] : 8'hxx, exp_b[k]);
            end
        end
        checks++;
        if (cyc_a.size() < 5 || cyc_a[4] - cyc_a[0] != 4) begin
            errors++;
            $display("FAIL single_consec: got span %0d want 4",
                     cyc_a.size() < 5 ? -1 : cyc_a[4] - cyc_a[0]);
        end
        checks++;
        if (pops_a != 1) begin
            errors++;
            $display("FAIL single_pops: got %0d want 1", pops_a);
        end
        checks++;
        if (seq_a !== 8'h01 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL single_seq: got seq=%h busy=%b want 01 0",
                     seq_a, busy_a);
        end
    endtask

    task automatic test_four();
        logic [7:0] exp_b[11];
        int bad, c;
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02,
                  8'h00, 8'h03, 8'h00, 8'h04, 8'h51};
        cap_b = {};
        pops_b = 0;
        bad = 0;
        c = 0;
        for (int k = 1; k <= 4; k++) qb.push_back(16'(k));
        rdy = 1'b1;
        while (cap_b.size() < 11 && c < 100) begin
            @(negedge clk);
            if (cap_b.size() > 0 && cap_b.size() < 11 && busy_b !== 1'b1)
                bad++;
            c++;
        end
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (k >= cap_b.size() || cap_b[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL four_byte%0d: got %h want %h", k,
                         k < cap_b.size() ? cap_b[k] : 8'hxx, exp_b[k]);
            end
        end
        checks++;
        if (pops_b != 4) begin
            errors++;
            $display("FAIL four_pops: got %0d want 4", pops_b);
        end
        checks++;
        if (bad != 0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL four_busy: got drops=%0d end=%b want 0 0",
                     bad, busy_b);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s[$];
        logic [7:0]  e[$];
        s = '{16'h1234, 16'hABCD, 16'h00FF, 16'h8001};
        mk_pkt(8'h01, s, e);
        cap_b = {};
        pops_b = 0;
        foreach (s[k]) qb.push_back(s[k]);
        wait_bytes(1'b1, 11, 1'b1, 400);
        rdy = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (k >= cap_b.size() || cap_b[k] !== e[k]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h want %h", k,
                         k < cap_b.size() ? cap_b[k] : 8'hxx, e[k]);
            end
        end
        checks++;
        if (pops_b != 4 || seq_b !== 8'h02) begin
            errors++;
            $display("FAIL bp_pops_seq: got %0d/%h want 4/02", pops_b, seq_b);
        end
    endtask

    task automatic test_starve();
        logic [15:0] s[$];
        logic [7:0]  e[$];
        int bad, p0;
        s = '{16'hC0DE, 16'h7F80, 16'h0102, 16'hFFFE};
        mk_pkt(8'h02, s, e);
        cap_b = {};
        pops_b = 0;
        bad = 0;
        qb.push_back(s[0]);
        qb.push_back(s[1]);
        wait_bytes(1'b1, 6, 1'b0, 50);
        p0 = pops_b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (vld_b !== 1'b0 || busy_b !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || pops_b != p0 || cap_b.size() != 6) begin
            errors++;
            $display("FAIL starve_idle: got bad=%0d pops=%0d bytes=%0d want 0 %0d 6",
                     bad, pops_b, cap_b.size(), p0);
        end
        qb.push_back(s[2]);
        qb.push_back(s[3]);
        wait_bytes(1'b1, 11, 1'b0, 50);
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (k >= cap_b.size() || cap_b[k] !== e[k]) begin
                errors++;
                $display("FAIL starve_byte%0d: got %h want %h", k,
                         k < cap_b.size() ? cap_b[k] : 8'hxx, e[k]);
            end
        end
        checks++;
        if (pops_b != 4) begin
            errors++;
            $display("FAIL starve_pops: got %0d want 4", pops_b);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  sum;
        logic [7:0]  iv;
        logic [15:0] sv;
        pulse_reset();
        rdy = 1'b1;
        for (int i = 0; i < 257; i++) begin
            iv = 8'(i);
            sv = {iv ^ 8'h5A, iv};
            cap_a = {};
            qa.push_back(sv);
            wait_bytes(1'b0, 5, 1'b0, 30);
            sum = 8'h00;
            foreach (cap_a[k]) sum = sum + cap_a[k];
            checks++;
            if (cap_a.size() != 5 || cap_a[1] !== iv || sum !== 8'h00 ||
                cap_a[2] !== sv[15:8] || cap_a[3] !== sv[7:0]) begin
                errors++;
                $display("FAIL wrap_pkt%0d: got seq=%h sum=%h want seq=%h sum=00",
                         i, cap_a.size() > 1 ? cap_a[1] : 8'hxx, sum, iv);
            end
        end
        @(negedge clk);
        checks++;
        if (seq_a !== 8'h01) begin
            errors++;
            $display("FAIL wrap_seq: got %h want 01", seq_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s[$];
        logic [15:0] t[$];
        logic [7:0]  e[$];
        pulse_reset();
        qb = {};
        cap_b = {};
        pops_b = 0;
        rdy = 1'b1;
        for (int k = 0; k < 16; k++) s.push_back(16'h1100 + 16'(k * 17));
        foreach (s[k]) qb.push_back(s[k]);
        wait_bytes(1'b1, 24, 1'b0, 100);
        rdy = 1'b0;
        checks++;
        if (vld_b !== 1'b1 || dat_b !== s[8][15:8] || pops_b != 9) begin
            errors++;
            $display("FAIL mid_msb: got v=%b d=%h pops=%0d want 1 %h 9",
                     vld_b, dat_b, pops_b, s[8][15:8]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({vld_b, dat_b, busy_b, seq_b, rd_b} !== 19'h0) begin
            errors++;
            $display("FAIL mid_async: v=%b d=%h b=%b s=%h r=%b want 0",
                     vld_b, dat_b, busy_b, seq_b, rd_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cap_b = {};
        rdy = 1'b1;
        t = '{s[9], s[10], s[11], s[12]};
        mk_pkt(8'h00, t, e);
        wait_bytes(1'b1, 11, 1'b0, 50);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (k >= cap_b.size() || cap_b[k] !== e[k]) begin
                errors++;
                $display("FAIL mid_byte%0d: got %h want %h", k,
                         k < cap_b.size() ? cap_b[k] : 8'hxx, e[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_four();
        test_backpressure();
        test_starve();
        test_wrap();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
